// File: rtl/memory_test_hw_button_pio.sv
// Avalon-MM input PIO: synchronizes external buttons/switches, optionally debounces
// them, latches edges into sticky W1C flags and raises a masked level interrupt.

module memory_test_hw_button_pio_lane #(
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_i,
    output logic stable_o
);
    logic sync1_q, sync2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= in_i;
            sync2_q <= sync1_q;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign stable_o = sync2_q;
        end else begin : g_debounce
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
            logic [CW-1:0] cnt_q;
            logic          stable_q;

            // A change is accepted on the Nth consecutive differing sample.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_q    <= '0;
                    stable_q <= 1'b0;
                end else if (sync2_q != stable_q) begin
                    if (cnt_q == CNT_LAST) begin
                        stable_q <= sync2_q;
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end else begin
                    cnt_q <= '0;
                end
            end
            assign stable_o = stable_q;
        end
    endgenerate
endmodule

module memory_test_hw_button_pio #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] ecap_q, ecap_d;
    logic [WIDTH-1:0] edge_det;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q;
    logic [1:0]       arm_cnt_q;
    logic             armed_q;
    logic             wr_en;
    logic             unused_wdata;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_lane
            memory_test_hw_button_pio_lane #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_lane (
                .clk     (clk),
                .reset_n (reset_n),
                .in_i    (in_port[gi]),
                .stable_o(stable[gi])
            );
        end
    endgenerate

    assign wr_en        = chipselect && !write_n;
    assign unused_wdata = ^writedata;

    always_comb begin
        case (EDGE_TYPE)
            0:       edge_det = stable & ~prev_q;
            1:       edge_det = ~stable & prev_q;
            default: edge_det = stable ^ prev_q;
        endcase
    end

    // Set wins over a same-cycle W1C so an edge is never dropped.
    always_comb begin
        ecap_d = ecap_q;
        mask_d = mask_q;
        if (wr_en && address == 2'd3) ecap_d = ecap_q & ~writedata[WIDTH-1:0];
        if (wr_en && address == 2'd2) mask_d = writedata[WIDTH-1:0];
        if (armed_q) ecap_d = ecap_d | edge_det;
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            2'd0:    readdata_d = 32'(stable);
            2'd2:    readdata_d = 32'(mask_q);
            2'd3:    readdata_d = 32'(ecap_q);
            default: readdata_d = '0;
        endcase
    end

    // Captures stay off for the first edges so inputs held high through reset
    // don't appear as rising edges once the synchronizer fills.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arm_cnt_q <= '0;
            armed_q   <= 1'b0;
        end else if (!armed_q) begin
            if (arm_cnt_q == 2'd2) armed_q   <= 1'b1;
            else                   arm_cnt_q <= arm_cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q     <= '0;
            mask_q     <= '0;
            ecap_q     <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            prev_q     <= stable;
            mask_q     <= mask_d;
            ecap_q     <= ecap_d;
            readdata_q <= readdata_d;
            irq_q      <= |(ecap_q & mask_q);
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;
endmodule

// File: doc/memory_test_hw_button_pio.md
Name: memory_test_hw_button_pio

Overview:
- Avalon-MM slave input PIO. The receive-side counterpart of the LED output port: it samples external push-buttons and switches into the clk domain.
- Optionally debounces each bit, captures edges into sticky per-bit flags, and raises a level interrupt gated by a software mask.
- Sits on the Nios II data master next to the LED PIO. Software polls or takes the IRQ, then clears captured edges.

Parameters:
- WIDTH, 4, number of input bits (1..32).
- DEBOUNCE_CYCLES, 0, cycles an input must be stable before it is accepted; 0 bypasses the debouncer.
- EDGE_TYPE, 0, edge to capture: 0 rising, 1 falling, 2 any.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  register word select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous external inputs.
- readdata  out  32  registered read data.
- irq  out  1  interrupt request, active-high level.

Behaviour:
- Clock and reset: clk; reset reset_n, asynchronous, active-low. All flops are cleared asynchronously on reset.
- Synchronizer: two-flop chain per bit (sync1, sync2), reset 0.
- Debouncer (DEBOUNCE_CYCLES>0):
  - Per-bit counter, width clog2(DEBOUNCE_CYCLES+1), plus a stable register; all reset 0.
  - If sync2 != stable, the counter increments. When it reaches DEBOUNCE_CYCLES-1, stable <= sync2 and the counter clears.
  - If sync2 == stable, the counter clears.
  - Net effect: a change is accepted after exactly DEBOUNCE_CYCLES consecutive differing samples. A glitch shorter than that is rejected.
- Debouncer bypass (DEBOUNCE_CYCLES=0): stable = sync2.
- Edge detect: prev <= stable every cycle, reset 0.
  - rise = stable & ~prev; fall = ~stable & prev. The edge vector is selected by EDGE_TYPE.
- Arming:
  - An armed flag resets to 0 and sets on the 3rd clk edge after reset deassertion.
  - While unarmed, prev tracks stable but no edges are captured. This prevents false edges from inputs held high through reset.
- Register map, word addresses:
  - 0 DATA (RO): {zero-extended, stable}. Writes are ignored.
  - 1: reserved, reads 0, writes ignored.
  - 2 IRQMASK (RW): WIDTH bits, reset 0.
  - 3 EDGECAPTURE (R/W1C): WIDTH bits, reset 0.
- Write cycle: a write happens when chipselect && ~write_n. It completes in one cycle with no wait states.
- EDGECAPTURE bit update:
  - Sets on a detected edge while armed.
  - Clears when written with a 1 in that bit.
  - Simultaneous set and clear in one cycle: set wins, so no edge is lost.
- Read cycle:
  - readdata is a registered mux: readdata <= mux(address) every clk. Read latency is 1 cycle; the system integrator declares readLatency=1.
  - Upper bits above WIDTH read 0.
  - readdata resets to 0.
- irq: irq <= |(EDGECAPTURE & IRQMASK), registered, reset 0.
  - Asserts 1 cycle after the capture bit is set, or after the mask is written.
  - Deasserts 1 cycle after the clear.
- Latency, pin to EDGECAPTURE set:
  - 2 sync cycles + DEBOUNCE_CYCLES + 1 edge cycle.
  - With DEBOUNCE_CYCLES=0: the bit is visible 3 clk after in_port changes (at a sampling edge), and irq 1 clk after that.
- Reset mid-operation: asynchronously clears everything, including counters, captures, mask and the armed flag. The post-reset arming rule then applies.
- Unused writedata bits above WIDTH are ignored.

Test Plan:
- Reset with in_port=4'hF held high, DEBOUNCE_CYCLES=0, EDGE_TYPE=0 -> after reset, DATA reads 0xF, EDGECAPTURE reads 0, irq=0 (no false rising edge).
- in_port bit1 rises, IRQMASK=0x2 -> EDGECAPTURE=0x2 at 3 clk; irq=1 the next cycle. Write 0x2 to address 3 -> EDGECAPTURE=0, irq=0 one cycle later.
- DEBOUNCE_CYCLES=8: pulse bit0 high for 7 cycles -> DATA stays 0, no capture. Hold high for 8 cycles -> DATA=0x1 and EDGECAPTURE=0x1.
- EDGE_TYPE=2: toggle bit3 0->1->0 with a clear between edges -> both edges are captured.
- Write-1-clear on bit2 in the same cycle a new bit2 edge is detected -> bit2 remains 1.
- IRQMASK=0 with captures pending -> irq=0. Then write IRQMASK=0xF -> irq=1 next cycle.
- Read of address 1 -> 0.
- Assert reset_n mid-debounce -> all registers and irq=0 immediately.
